io_responder: RTL and testbench

Memory-mapped I/O channel responder on the far side of the core's `IO_read_sel`/`IO_write_sel` interface. It decodes the 3-bit channel selects, returns 15-bit read data combinationally, and applies writes on the clock edge. It holds the output channel registers, a handshaked output port, synchronized input discretes, a keycode FIFO, a status/W1C register and a prescaled interval timer. It sits at top level beside ROM/RAM, wired directly to the core.

---
 rtl/io_responder_pkg.sv | 34 +++
 rtl/io_responder_if.sv | 24 ++
 rtl/io_responder_key_fifo.sv | 59 +++++
 rtl/io_responder.sv | 146 ++++++++++++++
 tb/tb_io_responder.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/io_responder_pkg.sv
// rtl/io_responder_pkg.sv - shared channel encoding and status layout for io_responder
// Purpose: channel select enum, status bit positions, data widths and the
//          keycode read-word formatter shared by the responder slice.
// Ports:   none (package)
package io_responder_pkg;

  localparam int DATA_W  = 15;
  localparam int KEY_W   = 5;
  localparam int COUNT_W = 3;

  typedef enum logic [2:0] {
    CH_NONE   = 3'd0,
    CH_OUT0   = 3'd1,
    CH_OUT1   = 3'd2,
    CH_IN0    = 3'd3,
    CH_KEY    = 3'd4,
    CH_STATUS = 3'd5,
    CH_TIMER  = 3'd6,
    CH_RSVD   = 3'd7
  } io_chan_t;

  localparam int ST_OUT1_VALID = 0;
  localparam int ST_OVERRUN    = 1;
  localparam int ST_KEY_OVF    = 2;
  localparam int ST_TMR_WRAP   = 3;

  // Bit 5 flags "a key is present" so a stored code of 0 is distinguishable
  // from an empty FIFO.
  function automatic logic [DATA_W-1:0] key_word(input logic nonempty,
                                                 input logic [KEY_W-1:0] head);
    return nonempty ? {9'b0, 1'b1, head} : '0;
  endfunction

endpackage

// File: rtl/io_responder_if.sv
// rtl/io_responder_if.sv - core-side I/O select/data bus
// Purpose: groups the core's read/write channel selects, data and stall.
// Ports:   master = core (drives selects, write data, stall; receives read data)
//          slave  = responder (receives selects; drives combinational read data)
interface io_bus_if;
  import io_responder_pkg::*;

  logic [2:0]        IO_read_sel;
  logic [DATA_W-1:0] IO_read_data;
  logic [2:0]        IO_write_sel;
  logic [DATA_W-1:0] IO_write_data;
  logic              stall;

  modport master (
    output IO_read_sel, IO_write_sel, IO_write_data, stall,
    input  IO_read_data
  );

  modport slave (
    input  IO_read_sel, IO_write_sel, IO_write_data, stall,
    output IO_read_data
  );

endinterface

// File: rtl/io_responder_key_fifo.sv
// rtl/io_responder_key_fifo.sv - keycode circular buffer
// Purpose: DEPTH-entry (2 or 4) FIFO of 5-bit keycodes with a separate count.
// Ports:   clock, reset (sync active-high); push/din write side;
//          pop/head read side (head valid when !empty); count, full, empty.
module key_fifo
  import io_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [KEY_W-1:0]   din,
  input  logic               pop,
  output logic [KEY_W-1:0]   head,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty
);

  localparam int                 PW      = $clog2(DEPTH);
  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(DEPTH);

  logic [KEY_W-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign head  = mem[rd_ptr];

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push
  // when it is popped concurrently.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_responder.sv
// rtl/io_responder.sv - memory-mapped I/O channel responder
// Purpose: decodes core channel selects; combinational reads, edge-applied
//          writes; output regs, handshaked output port, synchronized
//          discretes, keycode FIFO, W1C status and prescaled timer.
// Ports:   clock, reset (sync active-high); bus (io_bus_if.slave);
//          out0; out1_data/out1_valid/out1_ready handshake; in0_pins (async);
//          key_valid/key_code push; timer_irq (sticky timer-wrap level).
module io_responder
  import io_responder_pkg::*;
#(
  parameter int KEY_DEPTH      = 4,
  parameter int TIMER_PRESCALE = 1024
) (
  input  logic              clock,
  input  logic              reset,
  io_bus_if.slave           bus,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  input  logic [DATA_W-1:0] in0_pins,
  input  logic              key_valid,
  input  logic [KEY_W-1:0]  key_code,
  output logic              timer_irq
);

  localparam int             PSW     = (TIMER_PRESCALE > 2) ? $clog2(TIMER_PRESCALE) : 1;
  localparam logic [PSW-1:0] PS_LAST = PSW'(TIMER_PRESCALE - 1);

  io_chan_t            rsel;
  io_chan_t            wsel;
  logic                write_evt;
  logic                pop_evt;
  logic [DATA_W-1:0]   wd;

  logic [DATA_W-1:0]   in0_s1;
  logic [DATA_W-1:0]   in0_s2;
  logic                overrun;
  logic                key_ovf;
  logic                tmr_wrap;
  logic [DATA_W-1:0]   timer;
  logic [PSW-1:0]      presc;

  logic [KEY_W-1:0]    fifo_head;
  logic [COUNT_W-1:0]  fifo_count;
  logic                fifo_full;
  logic                fifo_empty;

  logic                wr_out0, wr_out1, wr_status, wr_timer;
  logic                tick;
  logic                overrun_set, key_ovf_set, wrap_set;
  logic [DATA_W-1:0]   status_word;

  assign rsel = io_chan_t'(bus.IO_read_sel);
  assign wsel = io_chan_t'(bus.IO_write_sel);
  assign wd   = bus.IO_write_data;

  assign write_evt = (wsel != CH_NONE) && !bus.stall;
  assign pop_evt   = (rsel == CH_KEY) && !bus.stall && !fifo_empty;

  assign wr_out0   = write_evt && (wsel == CH_OUT0);
  assign wr_out1   = write_evt && (wsel == CH_OUT1);
  assign wr_status = write_evt && (wsel == CH_STATUS);
  assign wr_timer  = write_evt && (wsel == CH_TIMER);

  // Overrun only when the pending word is lost; a rewrite on the accept edge
  // replaces a word the sink already took.
  assign overrun_set = wr_out1 && out1_valid && !out1_ready;
  assign key_ovf_set = key_valid && fifo_full && !pop_evt;
  assign tick        = (presc == PS_LAST);
  assign wrap_set    = tick && !wr_timer && (timer == 15'h7FFF);

  assign status_word = {8'b0, fifo_count, tmr_wrap, key_ovf, overrun, out1_valid};
  assign timer_irq   = tmr_wrap;

  key_fifo #(.DEPTH(KEY_DEPTH)) u_key_fifo (
    .clock (clock),
    .reset (reset),
    .push  (key_valid),
    .din   (key_code),
    .pop   (pop_evt),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    bus.IO_read_data = '0;
    case (rsel)
      CH_OUT0:   bus.IO_read_data = out0;
      CH_OUT1:   bus.IO_read_data = out1_data;
      CH_IN0:    bus.IO_read_data = in0_s2;
      CH_KEY:    bus.IO_read_data = key_word(!fifo_empty, fifo_head);
      CH_STATUS: bus.IO_read_data = status_word;
      CH_TIMER:  bus.IO_read_data = timer;
      default:   bus.IO_read_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out0       <= '0;
      out1_data  <= '0;
      out1_valid <= 1'b0;
      in0_s1     <= '0;
      in0_s2     <= '0;
      overrun    <= 1'b0;
      key_ovf    <= 1'b0;
      tmr_wrap   <= 1'b0;
      timer      <= '0;
      presc      <= '0;
    end else begin
      in0_s1 <= in0_pins;
      in0_s2 <= in0_s1;

      if (wr_out0) out0 <= wd;

      if (wr_out1) begin
        out1_data  <= wd;
        out1_valid <= 1'b1;
      end else if (out1_valid && out1_ready) begin
        out1_valid <= 1'b0;
      end

      if (wr_timer) begin
        timer <= wd;
        presc <= '0;
      end else if (tick) begin
        timer <= timer + 1'b1;
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end

      // Clear first, then set: a same-edge set event wins over W1C.
      if (wr_status && wd[ST_OVERRUN])  overrun  <= 1'b0;
      if (wr_status && wd[ST_KEY_OVF])  key_ovf  <= 1'b0;
      if (wr_status && wd[ST_TMR_WRAP]) tmr_wrap <= 1'b0;
      if (overrun_set) overrun  <= 1'b1;
      if (key_ovf_set) key_ovf  <= 1'b1;
      if (wrap_set)    tmr_wrap <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// tb/tb_io_responder.sv - self-checking bench for io_responder
module tb_io_responder;
  import io_responder_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [14:0] out0;
  logic [14:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [14:0] in0_pins;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        timer_irq;

  io_bus_if bus();

  io_responder #(.KEY_DEPTH(4), .TIMER_PRESCALE(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .out0       (out0),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .in0_pins   (in0_pins),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .timer_irq  (timer_irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  rs;
    logic [14:0] exp;
    logic        irq;
    logic [2:0]  ws;
    logic [14:0] wd;
    logic        st;
    logic        rdy;
    logic        kv;
    logic [4:0]  kc;
    logic [14:0] pins;
  } vec_t;

  typedef struct {
    logic [14:0] rd;
    logic        irq;
    int          idx;
  } sb_t;

  vec_t        tbl[$];
  sb_t         sb_q[$];
  logic [14:0] cur_pins = '0;
  int          vec_no   = 0;
  int          n_cmp    = 0;
  int          n_bad    = 0;

  function automatic vec_t mk(input logic [2:0] rs, input logic [14:0] exp, input logic irq,
                              input logic [2:0] ws, input logic [14:0] wd, input logic st,
                              input logic rdy, input logic kv, input logic [4:0] kc);
    vec_t v;
    v.rs = rs; v.exp = exp; v.irq = irq; v.ws = ws; v.wd = wd;
    v.st = st; v.rdy = rdy; v.kv = kv; v.kc = kc; v.pins = cur_pins;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [14:0] act, input logic [14:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got 0x%04h expected 0x%04h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    sb_t e;
    bus.IO_read_sel   = v.rs;
    bus.IO_write_sel  = v.ws;
    bus.IO_write_data = v.wd;
    bus.stall         = v.st;
    out1_ready        = v.rdy;
    key_valid         = v.kv;
    key_code          = v.kc;
    in0_pins          = v.pins;
    sb_q.push_back('{rd: v.exp, irq: v.irq, idx: vec_no});
    vec_no++;
    @(negedge clock);
    e = sb_q.pop_front();
    check("read_data", e.idx, bus.IO_read_data, e.rd);
    check("timer_irq", e.idx, {14'b0, timer_irq}, {14'b0, e.irq});
    @(posedge clock);
    #1;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    sb_t e;
    reset = 1'b1;
    bus.IO_read_sel = 3'd5; bus.IO_write_sel = 3'd0; bus.IO_write_data = '0; bus.stall = 1'b0;
    out1_ready = 1'b0; in0_pins = '0; key_valid = 1'b0; key_code = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out0", 0, out0, 15'h0);
    check("rst_out1_data", 0, out1_data, 15'h0);
    check("rst_out1_valid", 0, {14'b0, out1_valid}, 15'h0);
    check("rst_irq", 0, {14'b0, timer_irq}, 15'h0);
    check("rst_status", 0, bus.IO_read_data, 15'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // OUT0 / OUT1 handshake, overrun, W1C
    tbl.push_back(mk(1, 15'h0000, 0, 1, 15'h0ABC, 0, 0, 0, 0));
    tbl.push_back(mk(1, 15'h0ABC, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5, 15'h0000, 0, 2, 15'h1234, 0, 0, 0, 0));
    tbl.push_back(mk(5, 15'h0001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 15'h1234, 0, 2, 15'h0042, 0, 0, 0, 0));
    tbl.push_back(mk(5, 15'h0003, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 15'h0042, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(5, 15'h0002, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5, 15'h0002, 0, 5, 15'h0002, 0, 0, 0, 0));
    tbl.push_back(mk(5, 15'h0000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 15'h0000, 0, 2, 15'h0777, 0, 0, 0, 0));
    tbl.push_back(mk(5, 15'h0001, 0, 2, 15'h0888, 0, 1, 0, 0));
    tbl.push_back(mk(2, 15'h0888, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(5, 15'h0000, 0, 0, 0, 0, 0, 0, 0));
    run_tbl();
    check("out0_port", vec_no, out0, 15'h0ABC);
    check("out1_data_port", vec_no, out1_data, 15'h0888);

    // Keycode FIFO: overflow, stalled reads, push+pop when full/empty, set-wins W1C
    for (int k = 1; k <= 5; k++)
      tbl.push_back(mk(5, 15'((k == 5) ? 15'h40 : (k - 1) * 16), 0, 0, 0, 0, 0, 1, 5'(k)));
    tbl.push_back(mk(4, 15'h0021, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(4, 15'h0022, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(5, 15'h0034, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5, 15'h0034, 0, 0, 0, 0, 0, 1, 6));
    tbl.push_back(mk(5, 15'h0044, 0, 5, 15'h0004, 0, 0, 1, 7));
    tbl.push_back(mk(5, 15'h0044, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5, 15'h0044, 0, 5, 15'h0004, 0, 0, 0, 0));
    tbl.push_back(mk(5, 15'h0040, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4, 15'h0022, 0, 0, 0, 0, 0, 1, 8));
    tbl.push_back(mk(5, 15'h0040, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4, 15'h0023, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4, 15'h0024, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4, 15'h0026, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4, 15'h0028, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4, 15'h0000, 0, 0, 0, 0, 0, 1, 9));
    tbl.push_back(mk(5, 15'h0010, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4, 15'h0029, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5, 15'h0000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 15'h0ABC, 0, 1, 15'h1111, 1, 0, 0, 0));
    tbl.push_back(mk(1, 15'h0ABC, 0, 0, 0, 0, 0, 0, 0));
    run_tbl();

    // Timer wrap with prescale 2, irq level, W1C, write beats increment
    tbl.push_back(mk(0, 15'h0000, 0, 6, 15'h7FFE, 0, 0, 0, 0));
    tbl.push_back(mk(6, 15'h7FFE, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6, 15'h7FFE, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6, 15'h7FFF, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6, 15'h7FFF, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6, 15'h0000, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5, 15'h0008, 1, 5, 15'h0008, 0, 0, 0, 0));
    tbl.push_back(mk(5, 15'h0000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 15'h0000, 0, 6, 15'h7FFF, 0, 0, 0, 0));
    tbl.push_back(mk(6, 15'h7FFF, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6, 15'h7FFF, 0, 6, 15'h0100, 0, 0, 0, 0));
    tbl.push_back(mk(5, 15'h0000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(6, 15'h0100, 0, 0, 0, 0, 0, 0, 0));
    run_tbl();

    // Input synchronizer latency, ignored writes, reserved/none channels
    cur_pins = 15'h5555;
    tbl.push_back(mk(3, 15'h0000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3, 15'h0000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3, 15'h5555, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(7, 15'h0000, 0, 3, 15'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(7, 15'h0000, 0, 7, 15'h7FFF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 15'h0000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3, 15'h5555, 0, 0, 0, 0, 0, 0, 0));
    // Build up state for the reset check: pending word, 3 keys, timer wrap
    tbl.push_back(mk(0, 15'h0000, 0, 6, 15'h7FFF, 0, 0, 1, 1));
    tbl.push_back(mk(0, 15'h0000, 0, 2, 15'h00FF, 0, 0, 1, 2));
    tbl.push_back(mk(0, 15'h0000, 0, 0, 0, 0, 0, 1, 3));
    tbl.push_back(mk(5, 15'h0039, 1, 0, 0, 0, 0, 0, 0));
    run_tbl();

    // Reset mid-handshake with a concurrent push and write
    reset = 1'b1;
    out1_ready = 1'b1; key_valid = 1'b1; key_code = 5'd7;
    bus.IO_write_sel = 3'd2; bus.IO_write_data = 15'h1234; bus.IO_read_sel = 3'd0;
    @(posedge clock);
    #1;
    check("rst2_out0", vec_no, out0, 15'h0);
    check("rst2_out1_data", vec_no, out1_data, 15'h0);
    check("rst2_out1_valid", vec_no, {14'b0, out1_valid}, 15'h0);
    check("rst2_irq", vec_no, {14'b0, timer_irq}, 15'h0);
    for (int ch = 0; ch < 8; ch++) begin
      bus.IO_read_sel = 3'(ch);
      sb_q.push_back('{rd: 15'h0, irq: 1'b0, idx: ch});
      #1;
      e = sb_q.pop_front();
      check("rst2_read_ch", e.idx, bus.IO_read_data, e.rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
